// File: rtl/ringfifo.sv
// ringfifo: bridge between a ring node's client port and a host.
// Two independent circular FIFOs: RX carries node words to the host,
// TX carries host words to the node. Both are first-word-fall-through.
module ringfifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int CBITS = 3
) (
    input  logic             clk,
    input  logic             rst,
    // node client output side (feeds RX)
    input  logic [WIDTH-1:0] nodedata,
    input  logic             nodevalid,
    output logic             nodeack,
    // node client input side (fed from TX)
    output logic [WIDTH-1:0] clientdata,
    output logic             clientvalid,
    input  logic             clientack,
    // host write side (feeds TX)
    input  logic [WIDTH-1:0] host_wdata,
    input  logic             host_wvalid,
    output logic             host_wready,
    // host read side (fed from RX)
    output logic [WIDTH-1:0] host_rdata,
    output logic             host_rvalid,
    input  logic             host_rready,
    // occupancies
    output logic [CBITS-1:0] rxcount,
    output logic [CBITS-1:0] txcount
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CBITS-1:0] CNT_FULL = CBITS'(DEPTH);
    localparam logic [CBITS-1:0] CNT_ONE  = CBITS'(1);
    localparam logic [AW-1:0]    PTR_ONE  = AW'(1);

    // ------------------------------------------------------------------
    // RX FIFO state
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] rx_mem [DEPTH];
    logic [AW-1:0]    rx_wp;
    logic [AW-1:0]    rx_rp;
    logic [CBITS-1:0] rx_cnt;
    logic             ack_q;
    logic             rx_full;
    logic             rx_empty;
    logic             rx_push;
    logic             rx_pop;

    // ------------------------------------------------------------------
    // TX FIFO state
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] tx_mem [DEPTH];
    logic [AW-1:0]    tx_wp;
    logic [AW-1:0]    tx_rp;
    logic [CBITS-1:0] tx_cnt;
    logic             tx_full;
    logic             tx_empty;
    logic             tx_push;
    logic             tx_pop;

    // Status flags and handshake qualifiers; pushes on full and pops on
    // empty are masked here so the counters can never leave 0..DEPTH.
    always_comb begin
        rx_full  = (rx_cnt == CNT_FULL);
        rx_empty = (rx_cnt == '0);
        tx_full  = (tx_cnt == CNT_FULL);
        tx_empty = (tx_cnt == '0);
        // The !ack_q term blocks a second capture while the node is still
        // reacting to the previous ack; rst gating keeps reset cycles silent.
        rx_push  = rst && nodevalid && !rx_full && !ack_q;
        rx_pop   = rst && !rx_empty && host_rready;
        tx_push  = rst && host_wvalid && !tx_full;
        tx_pop   = rst && !tx_empty && clientack;
    end

    // Registered one-cycle ack pulse, issued on the same edge as the RX push.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ack_q <= 1'b0;
        end else begin
            ack_q <= rx_push;
        end
    end

    // RX storage write; contents are don't-care until counted valid.
    always_ff @(posedge clk) begin
        if (rx_push) begin
            rx_mem[rx_wp] <= nodedata;
        end
    end

    // RX pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_wp <= '0;
            rx_rp <= '0;
        end else begin
            if (rx_push) begin
                rx_wp <= rx_wp + PTR_ONE;
            end
            if (rx_pop) begin
                rx_rp <= rx_rp + PTR_ONE;
            end
        end
    end

    // RX occupancy; a simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_cnt <= '0;
        end else begin
            case ({rx_push, rx_pop})
                2'b10:   rx_cnt <= rx_cnt + CNT_ONE;
                2'b01:   rx_cnt <= rx_cnt - CNT_ONE;
                default: rx_cnt <= rx_cnt;
            endcase
        end
    end

    // TX storage write; contents are don't-care until counted valid.
    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_mem[tx_wp] <= host_wdata;
        end
    end

    // TX pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_wp <= '0;
            tx_rp <= '0;
        end else begin
            if (tx_push) begin
                tx_wp <= tx_wp + PTR_ONE;
            end
            if (tx_pop) begin
                tx_rp <= tx_rp + PTR_ONE;
            end
        end
    end

    // TX occupancy; a simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_cnt <= '0;
        end else begin
            case ({tx_push, tx_pop})
                2'b10:   tx_cnt <= tx_cnt + CNT_ONE;
                2'b01:   tx_cnt <= tx_cnt - CNT_ONE;
                default: tx_cnt <= tx_cnt;
            endcase
        end
    end

    // Output view: heads fall through, valids/ready derive from counts.
    always_comb begin
        nodeack     = ack_q;
        host_rvalid = !rx_empty;
        host_rdata  = rx_mem[rx_rp];
        host_wready = !tx_full;
        clientvalid = !tx_empty;
        clientdata  = tx_mem[tx_rp];
        rxcount     = rx_cnt;
        txcount     = tx_cnt;
    end

endmodule

// File: doc/ringfifo.md
RINGFIFO -- requirements
Module: ringfifo

Interface
REQ-001 Parameter WIDTH, default 16, width of one ring data word.
REQ-002 Parameter DEPTH, default 4, entries per FIFO; power of two, at least 2.
REQ-003 Parameter CBITS, default 3, count width; equals log2(DEPTH)+1.
REQ-004 Port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 Port rst  input  1  synchronous active-low reset.
REQ-006 Port nodedata  input  WIDTH  word offered by the ring node's client output (its toclient).
REQ-007 Port nodevalid  input  1  level; node holds it high with stable nodedata until acked.
REQ-008 Port nodeack  output  1  one-cycle pulse; word accepted into the RX FIFO.
REQ-009 Port clientdata  output  WIDTH  word offered to the node's client input (its fromclient).
REQ-010 Port clientvalid  output  1  level; TX FIFO non-empty.
REQ-011 Port clientack  input  1  one-cycle pulse from node; head word consumed.
REQ-012 Port host_wdata  input  WIDTH  host word to transmit.
REQ-013 Port host_wvalid / host_wready  input / output  1 each  host write handshake.
REQ-014 Port host_rdata  output  WIDTH  received word, head of the RX FIFO.
REQ-015 Port host_rvalid / host_rready  output / input  1 each  host read handshake.
REQ-016 Port rxcount, txcount  output  CBITS each  current FIFO occupancies.

Function
REQ-017 The block SHALL hold two independent circular FIFOs, RX (node to host) and TX (host to node), each DEPTH x WIDTH, with read/write pointers wrapping modulo DEPTH.
REQ-018 The block SHALL register nodeack high for exactly one cycle when nodevalid=1, RX not full and nodeack was 0 in the previous cycle; the RX push happens on that same edge, capturing nodedata.
REQ-019 The block SHALL never assert nodeack on two consecutive cycles (node drops nodevalid the cycle after seeing ack; no double capture).
REQ-020 The block SHALL hold nodeack low while RX is full; nodevalid stays pending, nothing is dropped.
REQ-021 host_rvalid SHALL equal RX non-empty, host_rdata SHALL be the RX head (first-word-fall-through), and an RX pop SHALL occur when host_rvalid and host_rready are both 1.
REQ-022 host_wready SHALL equal TX not full; a TX push SHALL occur when host_wvalid and host_wready are both 1.
REQ-023 clientvalid SHALL equal TX non-empty and clientdata SHALL be the TX head; clientack while clientvalid=1 SHALL pop one word, and clientack while clientvalid=0 SHALL be ignored.
REQ-024 A simultaneous push and pop on one FIFO SHALL leave its count unchanged and keep word order.
REQ-025 A push on full or a pop on empty SHALL be impossible by construction; counts SHALL stay within 0..DEPTH.
REQ-026 rxcount/txcount SHALL reflect occupancy registered after each edge.
REQ-027 Latency: a node word SHALL appear on host_rdata 1 cycle after its nodeack edge; a host word SHALL appear on clientdata 1 cycle after its push edge.

Reset
REQ-028 With rst=0 at a rising edge, both FIFOs SHALL empty and pointers and counts SHALL zero; nodeack, clientvalid and host_rvalid SHALL be 0, and host_wready SHALL be 1 on the following cycle.
REQ-029 Reset mid-transfer SHALL discard all stored words, and no nodeack SHALL be issued in any cycle where rst=0.

Verification
REQ-030 Node sends 0x1234 then 0x5678 (valid held until ack) -> two single-cycle nodeack pulses, never adjacent; host reads 0x1234 then 0x5678; rxcount peaks at 2.
REQ-031 Node offers 5 words with host_rready=0 and DEPTH=4 -> 4 acks and rxcount=4; 5th word remains pending; host pops one -> 5th word acked next eligible cycle.
REQ-032 Host writes 0xA001..0xA004 back-to-back -> host_wready falls after 4th; clientvalid=1 with clientdata=0xA001; 4 clientack pulses yield words in order; txcount returns to 0.
REQ-033 TX full with clientack and host_wvalid in the same cycle -> pop only; wready=1 next cycle; txcount 4->3.
REQ-034 RX at count 2 with simultaneous nodeack-push and host pop -> rxcount stays 2; order preserved across pointer wrap after 10 words.
REQ-035 rst=0 asserted with 3 words in each FIFO -> next cycle counts 0, rvalid=0, clientvalid=0, wready=1; spurious clientack while empty ignored.
